morse_symbol_rx: RTL and testbench
==================================

MORSE_SYMBOL_RX -- requirements
Module: morse_symbol_rx

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DASH_MIN_CYC     30_000_000   press length (cycles) at or above which a mark is a dash
  LETTER_GAP_CYC   60_000_000   release length (cycles) that closes a letter
  WORD_GAP_CYC     140_000_000  release length (cycles) that emits a word space; SHALL be > LETTER_GAP_CYC
  BTN_TIMEOUT_CYC  200_000_000  press length (cycles) that aborts the current letter
  MAX_SYM          6            maximum marks per letter
  FIFO_DEPTH       4            output record FIFO entries (power of two, >= 2)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk_100MHz   in   1                      single clock, rising edge
  reset_n      in   1                      asynchronous, active-low reset
  user_btn     in   1                      debounced, clk-synchronous key level (1 = pressed)
  rec_valid    out  1                      FIFO head record available
  rec_ready    in   1                      consumer accepts head record
  rec_space    out  1                      head record is a word space
  rec_sym      out  MAX_SYM                head marks; bit i = mark i (1 = dash, 0 = dot); unused bits 0
  rec_len      out  $clog2(MAX_SYM+1)      head mark count (0 for space)
  rec_ovf      out  1                      head letter had more than MAX_SYM marks
  abort_pulse  out  1                      one-cycle pulse on button timeout
  drop_pulse   out  1                      one-cycle pulse when a record is lost to a full FIFO
REQ-003 The design SHALL use one clock (clk_100MHz) and an asynchronous, active-low reset (reset_n).

Function
REQ-004 The FSM SHALL have the states IDLE, MARK, GAP, and ABORT, and all timing SHALL come from internal counters with no external timers.
REQ-005 A rising edge on user_btn SHALL be detected from a registered previous level, and the press counter SHALL be cleared on entry to MARK.
REQ-006 IDLE: on a rising edge the FSM SHALL go to MARK; all letter state (symbol register, length, ovf) SHALL already be clear.
REQ-007 MARK: the press counter SHALL increment each cycle user_btn=1 and saturate at BTN_TIMEOUT_CYC.
REQ-008 MARK, on release (user_btn=0): the mark SHALL be a dash if press count >= DASH_MIN_CYC, otherwise a dot.
  - If len < MAX_SYM: bit[len] SHALL be set to the mark and len SHALL increment.
  - If len = MAX_SYM: the letter ovf flag SHALL be set and len SHALL be unchanged.
  - The FSM SHALL then go to GAP with the gap counter cleared.
REQ-009 MARK: when the press count reaches BTN_TIMEOUT_CYC with the button still held:
  - The current letter SHALL be discarded and abort_pulse asserted for one cycle.
  - The FSM SHALL go to ABORT and stay there until release, then go to IDLE with no record pushed.
REQ-010 GAP: the gap counter SHALL increment each cycle user_btn=0 and saturate at WORD_GAP_CYC.
REQ-011 GAP: when the gap counter reaches LETTER_GAP_CYC, exactly one letter record SHALL be pushed {space=0, sym, len, ovf}, and the letter state SHALL be cleared.
REQ-012 GAP: when the gap counter reaches WORD_GAP_CYC, exactly one space record SHALL be pushed {space=1, sym=0, len=0, ovf=0}, and the FSM SHALL go to IDLE.
REQ-013 GAP, on a rising edge:
  - Before LETTER_GAP_CYC: the FSM SHALL go to MARK within the same letter.
  - At or after LETTER_GAP_CYC and before WORD_GAP_CYC: the FSM SHALL go to MARK starting a new letter, and no space record SHALL be pushed.
REQ-014 Records SHALL go through a FIFO of FIFO_DEPTH entries.
  - Push-to-rec_valid latency SHALL be 1 cycle when the FIFO is empty.
  - rec_* SHALL be stable while rec_valid=1 and rec_ready=0.
REQ-015 A pop SHALL occur on rec_valid & rec_ready.
  - A push and a pop in the same cycle on a full FIFO SHALL both succeed.
  - A push into a full FIFO with no pop SHALL drop the new record and assert drop_pulse for one cycle.
REQ-016 Pointers SHALL wrap modulo FIFO_DEPTH, with full and empty distinguished by an extra pointer bit.
REQ-017 The first release after reset, with no preceding press, SHALL cause no action.

Reset
REQ-018 While reset_n=0, the following SHALL hold:
  - state=IDLE and all counters = 0
  - letter state cleared
  - FIFO empty
  - rec_valid=0, rec_space=0, rec_sym=0, rec_len=0, rec_ovf=0, abort_pulse=0, drop_pulse=0
  - previous-button register = 0
REQ-019 Reset asserted mid-letter or mid-gap SHALL discard all pending and queued records, and nothing SHALL be emitted after deassertion until a new press.

Verification (DASH_MIN_CYC=3, LETTER_GAP_CYC=5, WORD_GAP_CYC=10, BTN_TIMEOUT_CYC=20, MAX_SYM=5, FIFO_DEPTH=2, rec_ready=1 unless stated)
REQ-020 Press 1 cycle, gap 2 cycles, press 4 cycles, gap 12 cycles -> letter record with sym=5'b00010, len=2, ovf=0, space=0, followed by a space record with len=0 and space=1.
REQ-021 Six presses of 1 cycle each, separated by 2-cycle gaps, then a 6-cycle gap -> one record with len=5, sym=0, ovf=1.
REQ-022 Press held 25 cycles with 2 dots already in the letter -> abort_pulse high exactly 1 cycle at press count 20, no record pushed, state IDLE after release.
REQ-023 rec_ready=0, then 3 letters each closed by a 6-cycle gap -> first 2 records held stable, drop_pulse on the third push; after rec_ready=1, exactly 2 records popped in order.
REQ-024 Press 1 cycle, gap 7 cycles, press 1 cycle, gap 12 cycles -> two letter records (len=1 each) and one space record, with no space between the letters.
REQ-025 reset_n pulsed low for 1 cycle during a gap with 1 record queued -> rec_valid=0 immediately, and no record appears afterwards without a new press.

Source files
------------

// File: rtl/morse_symbol_rx.sv
// Morse key decoder: times presses/releases into dot/dash letter records and word-space records.
// Latency: record visible 1 cycle after the closing gap count; backpressure via rec_valid/rec_ready, new records dropped when the FIFO is full.

module morse_symbol_rx #(
   parameter int DASH_MIN_CYC    = 30_000_000,
   parameter int LETTER_GAP_CYC  = 60_000_000,
   parameter int WORD_GAP_CYC    = 140_000_000,
   parameter int BTN_TIMEOUT_CYC = 200_000_000,
   parameter int MAX_SYM         = 6,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                           clk_100MHz,
   input  logic                           reset_n,
   input  logic                           user_btn,
   output logic                           rec_valid,
   input  logic                           rec_ready,
   output logic                           rec_space,
   output logic [MAX_SYM-1:0]             rec_sym,
   output logic [$clog2(MAX_SYM+1)-1:0]   rec_len,
   output logic                           rec_ovf,
   output logic                           abort_pulse,
   output logic                           drop_pulse
);
   localparam int LW = $clog2(MAX_SYM + 1);
   localparam int PW = $clog2(BTN_TIMEOUT_CYC + 1);
   localparam int GW = $clog2(WORD_GAP_CYC + 1);
   localparam logic [PW-1:0] DASH_MIN  = PW'(DASH_MIN_CYC);
   localparam logic [PW-1:0] TMO       = PW'(BTN_TIMEOUT_CYC);
   localparam logic [PW-1:0] TMO_M1    = PW'(BTN_TIMEOUT_CYC - 1);
   localparam logic [GW-1:0] LETTER_M1 = GW'(LETTER_GAP_CYC - 1);
   localparam logic [GW-1:0] WORD      = GW'(WORD_GAP_CYC);
   localparam logic [GW-1:0] WORD_M1   = GW'(WORD_GAP_CYC - 1);
   localparam logic [LW-1:0] MAX_LEN   = LW'(MAX_SYM);

   typedef enum logic [1:0] {IDLE, MARK, GAP, ABORT} state_t;

   typedef struct packed {
      logic               space;
      logic               ovf;
      logic [LW-1:0]      len;
      logic [MAX_SYM-1:0] sym;
   } rec_t;

   state_t             state, state_n;
   logic [PW-1:0]      press_cnt, press_n;
   logic [GW-1:0]      gap_cnt, gap_n;
   logic [MAX_SYM-1:0] sym, sym_n;
   logic [LW-1:0]      len, len_n;
   logic               ovf, ovf_n;
   logic               btn_prev;
   logic               rise;
   logic               is_dash;
   logic               abort_n;
   logic               push;
   rec_t               push_rec;
   logic               fifo_full;
   logic               pop;
   logic [$bits(rec_t)-1:0] head_dat;
   rec_t               head;

   assign rise = user_btn & ~btn_prev;

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         press_cnt   <= '0;
         gap_cnt     <= '0;
         sym         <= '0;
         len         <= '0;
         ovf         <= 1'b0;
         btn_prev    <= 1'b0;
         abort_pulse <= 1'b0;
         drop_pulse  <= 1'b0;
      end else begin
         state       <= state_n;
         press_cnt   <= press_n;
         gap_cnt     <= gap_n;
         sym         <= sym_n;
         len         <= len_n;
         ovf         <= ovf_n;
         btn_prev    <= user_btn;
         abort_pulse <= abort_n;
         drop_pulse  <= push & fifo_full & ~pop;
      end
   end

   always_comb begin
      state_n  = state;
      press_n  = press_cnt;
      gap_n    = gap_cnt;
      sym_n    = sym;
      len_n    = len;
      ovf_n    = ovf;
      is_dash  = 1'b0;
      abort_n  = 1'b0;
      push     = 1'b0;
      push_rec = '0;
      case (state)
         IDLE: begin
            press_n = '0;
            gap_n   = '0;
            if (rise) state_n = MARK;
         end
         MARK: begin
            if (!user_btn) begin
               is_dash = (press_cnt >= DASH_MIN);
               if (len < MAX_LEN) begin
                  for (int i = 0; i < MAX_SYM; i++) begin
                     if (LW'(i) == len) sym_n[i] = is_dash;
                  end
                  len_n = len + LW'(1);
               end else begin
                  ovf_n = 1'b1;
               end
               gap_n   = '0;
               state_n = GAP;
            end else if (press_cnt >= TMO_M1) begin
               // counter lands on the timeout value in the same cycle the pulse is raised
               press_n = TMO;
               abort_n = 1'b1;
               sym_n   = '0;
               len_n   = '0;
               ovf_n   = 1'b0;
               state_n = ABORT;
            end else begin
               press_n = press_cnt + PW'(1);
            end
         end
         GAP: begin
            if (rise) begin
               press_n = '0;
               state_n = MARK;
            end else begin
               if (gap_cnt != WORD) gap_n = gap_cnt + GW'(1);
               if (gap_cnt == LETTER_M1) begin
                  push           = 1'b1;
                  push_rec.space = 1'b0;
                  push_rec.ovf   = ovf;
                  push_rec.len   = len;
                  push_rec.sym   = sym;
                  sym_n          = '0;
                  len_n          = '0;
                  ovf_n          = 1'b0;
               end
               if (gap_cnt == WORD_M1) begin
                  push           = 1'b1;
                  push_rec.space = 1'b1;
                  state_n        = IDLE;
               end
            end
         end
         ABORT: begin
            if (!user_btn) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign pop = rec_valid & rec_ready;

   fifo #(
      .W     ($bits(rec_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_rec_fifo (
      .clk_100MHz (clk_100MHz),
      .reset_n    (reset_n),
      .wr_vld     (push),
      .wr_dat     (push_rec),
      .full       (fifo_full),
      .rd_vld     (rec_valid),
      .rd_rdy     (rec_ready),
      .rd_dat     (head_dat)
   );

   // head fields read as zero whenever nothing is queued
   assign head      = rec_valid ? rec_t'(head_dat) : '0;
   assign rec_space = head.space;
   assign rec_sym   = head.sym;
   assign rec_len   = head.len;
   assign rec_ovf   = head.ovf;
endmodule

// Generic register FIFO with show-ahead head; write into a full FIFO succeeds only alongside a read.
// Latency: written entry visible on rd_dat the cycle after the write.
module fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk_100MHz,
   input  logic         reset_n,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   output logic         full,
   output logic         rd_vld,
   input  logic         rd_rdy,
   output logic [W-1:0] rd_dat
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;
   logic         do_wr, do_rd;

   assign rd_vld = (wr_ptr != rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_rd  = rd_vld & rd_rdy;
   assign do_wr  = wr_vld & (~full | do_rd);
   assign rd_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
            wr_ptr              <= wr_ptr + PTR_ONE;
         end
         if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end
endmodule

// File: tb/tb_morse_symbol_rx.sv
// Directed bench for morse_symbol_rx with small timing parameters.
module tb_morse_symbol_rx;
   logic       clk_100MHz = 1'b0;
   logic       reset_n;
   logic       user_btn;
   logic       rec_valid;
   logic       rec_ready;
   logic       rec_space;
   logic [4:0] rec_sym;
   logic [2:0] rec_len;
   logic       rec_ovf;
   logic       abort_pulse;
   logic       drop_pulse;

   int checks   = 0;
   int failures = 0;
   int abort_cnt;
   int drop_cnt;
   int abort_idx;
   logic [9:0] got_q [$];
   logic [9:0] exp_q [$];

   morse_symbol_rx #(
      .DASH_MIN_CYC    (3),
      .LETTER_GAP_CYC  (5),
      .WORD_GAP_CYC    (10),
      .BTN_TIMEOUT_CYC (20),
      .MAX_SYM         (5),
      .FIFO_DEPTH      (2)
   ) dut (
      .clk_100MHz  (clk_100MHz),
      .reset_n     (reset_n),
      .user_btn    (user_btn),
      .rec_valid   (rec_valid),
      .rec_ready   (rec_ready),
      .rec_space   (rec_space),
      .rec_sym     (rec_sym),
      .rec_len     (rec_len),
      .rec_ovf     (rec_ovf),
      .abort_pulse (abort_pulse),
      .drop_pulse  (drop_pulse)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   // handshakes seen at the falling edge complete on the following rising edge
   always @(negedge clk_100MHz) begin
      if (reset_n) begin
         if (rec_valid && rec_ready) got_q.push_back({rec_space, rec_ovf, rec_len, rec_sym});
         if (abort_pulse) abort_cnt++;
         if (drop_pulse) drop_cnt++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] mk(input logic sp, input logic ov, input logic [2:0] ln,
                                     input logic [4:0] sy);
      return {sp, ov, ln, sy};
   endfunction

   task automatic tick();
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic press(input int n);
      user_btn = 1'b1;
      repeat (n) tick();
      user_btn = 1'b0;
   endtask

   task automatic gap(input int n);
      user_btn = 1'b0;
      repeat (n) tick();
   endtask

   task automatic clear_obs();
      got_q.delete();
      exp_q.delete();
      abort_cnt = 0;
      drop_cnt  = 0;
   endtask

   task automatic check_recs(input string tag);
      check_eq($sformatf("%s_count", tag), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check_eq($sformatf("%s_rec%0d", tag, i), {22'd0, got_q[i]}, {22'd0, exp_q[i]});
   endtask

   initial begin
      reset_n   = 1'b0;
      user_btn  = 1'b0;
      rec_ready = 1'b1;
      clear_obs();
      repeat (3) tick();
      check_eq("rst_valid", rec_valid, 1'b0);
      check_eq("rst_space", rec_space, 1'b0);
      check_eq("rst_sym", rec_sym, 5'd0);
      check_eq("rst_len", rec_len, 3'd0);
      check_eq("rst_ovf", rec_ovf, 1'b0);
      check_eq("rst_abort", abort_pulse, 1'b0);
      check_eq("rst_drop", drop_pulse, 1'b0);
      reset_n = 1'b1;
      gap(15);
      check_recs("idle");

      // dot then dash, word gap
      clear_obs();
      press(1); gap(2); press(4);
      gap(5);
      check_eq("lat_before", rec_valid, 1'b0);
      gap(1);
      check_eq("lat_valid", rec_valid, 1'b1);
      check_eq("lat_len", rec_len, 3'd2);
      gap(6); gap(3);
      exp_q.push_back(mk(1'b0, 1'b0, 3'd2, 5'b00010));
      exp_q.push_back(mk(1'b1, 1'b0, 3'd0, 5'b00000));
      check_recs("dotdash");

      // six dots overflow a five-mark letter
      clear_obs();
      for (int i = 0; i < 5; i++) begin press(1); gap(2); end
      press(1); gap(6); gap(8);
      exp_q.push_back(mk(1'b0, 1'b1, 3'd5, 5'b00000));
      exp_q.push_back(mk(1'b1, 1'b0, 3'd0, 5'b00000));
      check_recs("ovf");

      // long hold aborts a letter holding two dots
      clear_obs();
      abort_idx = -1;
      press(1); gap(2); press(1); gap(2);
      user_btn = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         tick();
         @(negedge clk_100MHz);
         if (abort_pulse && abort_idx < 0) abort_idx = i;
      end
      gap(15);
      check_eq("abort_idx", abort_idx, 21);
      check_eq("abort_cnt", abort_cnt, 1);
      check_recs("abort");
      clear_obs();
      press(1); gap(12); gap(3);
      exp_q.push_back(mk(1'b0, 1'b0, 3'd1, 5'b00000));
      exp_q.push_back(mk(1'b1, 1'b0, 3'd0, 5'b00000));
      check_recs("post_abort");

      // letter gap then a new letter, single word space
      clear_obs();
      press(1); gap(7); press(1); gap(12); gap(3);
      exp_q.push_back(mk(1'b0, 1'b0, 3'd1, 5'b00000));
      exp_q.push_back(mk(1'b0, 1'b0, 3'd1, 5'b00000));
      exp_q.push_back(mk(1'b1, 1'b0, 3'd0, 5'b00000));
      check_recs("two_letters");

      // consumer stalled: FIFO of two fills, later pushes dropped
      clear_obs();
      rec_ready = 1'b0;
      press(4); gap(6);
      check_eq("hold1_len", rec_len, 3'd1);
      check_eq("hold1_sym", rec_sym, 5'b00001);
      press(1); gap(2); press(4); gap(6);
      check_eq("hold2_sym", rec_sym, 5'b00001);
      press(1); gap(6);
      tick();
      check_eq("drop_third", drop_cnt, 1);
      gap(6);
      check_eq("drop_space", drop_cnt, 2);
      check_eq("hold3_valid", rec_valid, 1'b1);
      check_eq("hold3_len", rec_len, 3'd1);
      check_eq("hold3_sym", rec_sym, 5'b00001);
      check_eq("no_pop", got_q.size(), 0);
      rec_ready = 1'b1;
      gap(4);
      exp_q.push_back(mk(1'b0, 1'b0, 3'd1, 5'b00001));
      exp_q.push_back(mk(1'b0, 1'b0, 3'd2, 5'b00010));
      check_recs("drain");

      // reset mid-gap flushes the queue and the pending word space
      clear_obs();
      rec_ready = 1'b0;
      press(1); gap(7);
      check_eq("queued_valid", rec_valid, 1'b1);
      reset_n = 1'b0;
      #1;
      check_eq("rst_flush_valid", rec_valid, 1'b0);
      tick();
      reset_n   = 1'b1;
      rec_ready = 1'b1;
      gap(15);
      check_eq("post_rst_valid", rec_valid, 1'b0);
      check_recs("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
